cache_ctrl: RTL
===============

CACHE_CTRL -- requirements
Module: cache_ctrl

Interface
REQ-001 Parameter MEM_WAIT, default 2: clock cycles each main-memory access is held; legal range 1 to 15.
REQ-002 Parameter LINES, default 16: number of direct-mapped one-byte lines; power of two, 2 to 64.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous and active-high.
REQ-005 Port cpu_rd, input, 1: CPU read request.
REQ-006 Port cpu_wr, input, 1: CPU write request.
REQ-007 Port cpu_addr, input, 8: byte address.
REQ-008 Port cpu_wdata, input, 8: write data.
REQ-009 Port cpu_rdata, output, 8: read data.
REQ-010 Port cpu_stall, output, 1: high while the request is not complete.
REQ-011 Port MMRead, output, 1: main-memory read strobe, registered.
REQ-012 Port MMWrite, output, 1: main-memory write strobe, registered.
REQ-013 Port ABUS, output, 8: main-memory address, registered.
REQ-014 Port CachetoMem, output, 8: main-memory write data, registered.
REQ-015 Port MemtoCache, input, 8: main-memory read data.

Function
REQ-016 Address split: index = cpu_addr[log2(LINES)-1:0]; tag = the remaining upper bits. Each line holds valid, tag and 8-bit data.
REQ-017 FSM states are IDLE, RD_MEM, WR_MEM and DONE.
REQ-018 Requests are accepted only in IDLE. When cpu_rd and cpu_wr are both high, the write wins and the read is ignored.
REQ-019 Read hit in IDLE: cpu_stall = 0 in the same cycle; cpu_rdata = line data, combinationally; state stays IDLE.
REQ-020 Read miss in IDLE: cpu_stall = 1 combinationally. Next state RD_MEM with MMRead = 1 and ABUS = cpu_addr.
REQ-021 RD_MEM lasts exactly MEM_WAIT cycles, counted by an internal counter. On the last cycle:
- MemtoCache is written into the line, the tag is written and valid is set;
- MMRead is cleared;
- next state is DONE.
REQ-022 Write in IDLE: cpu_stall = 1. Next state WR_MEM with MMWrite = 1, ABUS = cpu_addr and CachetoMem = cpu_wdata.
- On a tag hit, the line data is updated on the same edge.
- On a miss, the line is not allocated.
REQ-023 WR_MEM lasts exactly MEM_WAIT cycles. MMWrite is cleared on the last cycle; next state is DONE.
REQ-024 DONE lasts one cycle: cpu_stall = 0 and cpu_rdata = the filled line data (reads). Next state is IDLE.
REQ-025 The CPU holds cpu_rd, cpu_wr, cpu_addr and cpu_wdata stable while cpu_stall = 1. The controller samples them only in IDLE.
REQ-026 MMRead and MMWrite are never both 1. ABUS and CachetoMem stay constant for the whole RD_MEM or WR_MEM period.
REQ-027 With no request in IDLE: cpu_stall = 0, MMRead = MMWrite = 0, and cpu_rdata shows the indexed line data.
REQ-028 Read miss latency is MEM_WAIT + 2 cycles from request to the stall-free cycle. Write latency is the same.

Reset
REQ-029 While rst = 1, asynchronously:
- state = IDLE, counter = 0, all valid bits = 0;
- MMRead = MMWrite = 0, ABUS = 0, CachetoMem = 0;
- cpu_stall = 0, cpu_rdata = 0.
REQ-030 Reset during RD_MEM or WR_MEM aborts the access immediately; no line is written. After release, the first read of any address is a miss.

Configuration
REQ-031 Macro CACHE_CTRL_STATS_EN, when defined, adds two outputs:
- hit_cnt (16 bits): increments on each read hit accepted in IDLE;
- miss_cnt (16 bits): increments on each read miss accepted in IDLE.
Both saturate at 16'hFFFF and reset to 0. Without the macro, neither port nor any counter logic exists, and all other behaviour is identical.

Verification
REQ-032 Reset, then cpu_rd with addr 8'h23, MEM[8'h23] = 8'h5A -> MMRead = 1 with ABUS = 8'h23 for 2 cycles; DONE gives cpu_rdata = 8'h5A with stall = 0; 4 cycles total.
REQ-033 Repeat the read of 8'h23 -> stall = 0 in the same cycle, cpu_rdata = 8'h5A, MMRead stays 0.
REQ-034 Write 8'hC3 to 8'h23 (hit) -> MMWrite = 1 and CachetoMem = 8'hC3 for 2 cycles; a following read of 8'h23 hits and returns 8'hC3.
REQ-035 Read 8'h33 (same index as 8'h23, different tag) -> miss; the line is replaced by MEM[8'h33]. A following read of 8'h23 misses again.
REQ-036 Assert rst mid-RD_MEM -> MMRead = 0 immediately; after release, a read of 8'h23 misses.
REQ-037 With CACHE_CTRL_STATS_EN defined, the REQ-032 to REQ-035 sequence -> hit_cnt = 2, miss_cnt = 3.

Source files
------------

// File: rtl/cache_ctrl.sv
// Direct-mapped, one-byte-per-line cache controller with write-through to main memory.
// Read hits complete combinationally in IDLE; misses and all writes go to main memory
// for MEM_WAIT cycles, followed by a one-cycle DONE.
// Optional feature: define CACHE_CTRL_STATS_EN to add saturating read hit/miss counters.
module cache_ctrl #(
    parameter int unsigned MEM_WAIT = 2,
    parameter int unsigned LINES    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_stall,
    output logic        MMRead,
    output logic        MMWrite,
    output logic [7:0]  ABUS,
    output logic [7:0]  CachetoMem,
    input  logic [7:0]  MemtoCache
`ifdef CACHE_CTRL_STATS_EN
    ,
    output logic [15:0] hit_cnt,
    output logic [15:0] miss_cnt
`endif
);
    localparam int unsigned IDX_W = $clog2(LINES);
    localparam int unsigned TAG_W = 8 - IDX_W;
    localparam logic [3:0]  LAST  = 4'(MEM_WAIT - 1);

    typedef enum logic [1:0] {IDLE, RD_MEM, WR_MEM, DONE} state_e;

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [7:0]       data_q [LINES];

    logic [IDX_W-1:0] req_idx, acc_idx, rd_idx, line_idx;
    logic [TAG_W-1:0] req_tag;
    logic             req_hit;
    logic             line_we, line_fill;
    logic [7:0]       line_wdata;
    logic             mm_read_d, mm_write_d;
    logic [7:0]       abus_d, c2m_d;

    assign req_idx = cpu_addr[IDX_W-1:0];
    assign req_tag = cpu_addr[7:IDX_W];
    // ABUS holds the address of the access in flight, so it also indexes the line afterwards.
    assign acc_idx = ABUS[IDX_W-1:0];
    assign req_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

    // Next-state, memory-strobe next values, line write control and CPU-facing outputs.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mm_read_d  = MMRead;
        mm_write_d = MMWrite;
        abus_d     = ABUS;
        c2m_d      = CachetoMem;
        cpu_stall  = 1'b0;
        rd_idx     = req_idx;
        line_we    = 1'b0;
        line_fill  = 1'b0;
        line_idx   = req_idx;
        line_wdata = cpu_wdata;
        unique case (state_q)
            IDLE: begin
                // Write takes priority over a simultaneous read.
                if (cpu_wr) begin
                    cpu_stall  = 1'b1;
                    state_d    = WR_MEM;
                    mm_write_d = 1'b1;
                    abus_d     = cpu_addr;
                    c2m_d      = cpu_wdata;
                    line_we    = req_hit;
                end else if (cpu_rd && !req_hit) begin
                    cpu_stall = 1'b1;
                    state_d   = RD_MEM;
                    mm_read_d = 1'b1;
                    abus_d    = cpu_addr;
                end
            end
            RD_MEM: begin
                cpu_stall = 1'b1;
                rd_idx    = acc_idx;
                if (cnt_q == LAST) begin
                    cnt_d      = 4'd0;
                    mm_read_d  = 1'b0;
                    state_d    = DONE;
                    line_we    = 1'b1;
                    line_fill  = 1'b1;
                    line_idx   = acc_idx;
                    line_wdata = MemtoCache;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            WR_MEM: begin
                cpu_stall = 1'b1;
                rd_idx    = acc_idx;
                if (cnt_q == LAST) begin
                    cnt_d      = 4'd0;
                    mm_write_d = 1'b0;
                    state_d    = DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: begin
                rd_idx  = acc_idx;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        cpu_rdata = data_q[rd_idx];
        // CPU-facing outputs read as zero for as long as reset is held.
        if (rst) begin
            cpu_stall = 1'b0;
            cpu_rdata = 8'h00;
        end
    end

    // State, wait counter and registered main-memory interface.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            MMRead     <= 1'b0;
            MMWrite    <= 1'b0;
            ABUS       <= 8'h00;
            CachetoMem <= 8'h00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            MMRead     <= mm_read_d;
            MMWrite    <= mm_write_d;
            ABUS       <= abus_d;
            CachetoMem <= c2m_d;
        end
    end

    // Line storage: fills set valid and tag; write hits update data only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < int'(LINES); i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= 8'h00;
            end
        end else if (line_we) begin
            data_q[line_idx] <= line_wdata;
            if (line_fill) begin
                valid_q[line_idx] <= 1'b1;
                tag_q[line_idx]   <= ABUS[7:IDX_W];
            end
        end
    end

`ifdef CACHE_CTRL_STATS_EN
    logic rd_accept;
    assign rd_accept = (state_q == IDLE) && cpu_rd && !cpu_wr;

    // Saturating counters of read requests accepted in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt  <= 16'h0000;
            miss_cnt <= 16'h0000;
        end else if (rd_accept) begin
            if (req_hit && hit_cnt != 16'hFFFF) begin
                hit_cnt <= hit_cnt + 16'h0001;
            end
            if (!req_hit && miss_cnt != 16'hFFFF) begin
                miss_cnt <= miss_cnt + 16'h0001;
            end
        end
    end
`endif

endmodule
